// File: rtl/lighting_pkg.sv
// Shared types, widths and the lamp thermometer decode for the lighting sequencer.
package lighting_pkg;

    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned NUM_LAMPS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHADE,
        LAMP,
        SETTLE,
        DONE
    } state_t;

    // Latched request payload: lamp count and shade level to ramp towards.
    typedef struct packed {
        logic [LEVEL_W-1:0] lightnum;
        logic [LEVEL_W-1:0] wshade;
    } target_t;

    // Lamp enable i is on when i is below the active lamp count.
    function automatic logic [NUM_LAMPS-1:0] therm16(input logic [LEVEL_W-1:0] n);
        logic [NUM_LAMPS-1:0] e;
        e = '0;
        for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
            e[i] = ((LEVEL_W + 1)'(i) < {1'b0, n});
        end
        return e;
    endfunction

endpackage

// File: rtl/lighting_sequencer_step_timer.sv
// Free-running step counter shared by every timed state of the sequencer.
// Counts 0..limit-1 and wraps; tc_c flags the last count, pre_tc_c the one before.
module step_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc_c,
    output logic             pre_tc_c
);

    logic [CNT_W-1:0] count;

    // Restart on clear or at the end of each interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tc_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal and pre-terminal decodes; pre-terminal lets the owner register a pulse for the terminal cycle.
    always_comb begin
        tc_c     = (count == (limit - CNT_W'(1)));
        pre_tc_c = (({1'b0, count} + (CNT_W + 1)'(2)) == {1'b0, limit});
    end

endmodule

// File: rtl/lighting_sequencer.sv
// Applies requested lamp count and shade level by ramping the shade motor, then the lamp bank, one unit per step.
module lighting_sequencer
    import lighting_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [LEVEL_W-1:0]   tgt_lightnum,
    input  logic [LEVEL_W-1:0]   tgt_wshade,
    output logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [LEVEL_W-1:0]   cur_lightnum,
    output logic [LEVEL_W-1:0]   cur_wshade,
    output logic [NUM_LAMPS-1:0] lightstate,
    output logic                 shade_up,
    output logic                 shade_dn
);

    localparam int unsigned MAX_LIMIT = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_LIMIT + 1);

    state_t             state;
    state_t             state_nxt;
    target_t            tgt;
    logic               ws_step;
    logic               ln_step;
    logic [LEVEL_W-1:0] ws_toward;
    logic [LEVEL_W-1:0] ln_toward;
    logic               timer_clr;
    logic [CNT_W-1:0]   timer_limit;
    logic               tc;
    logic               pre_tc;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .limit    (timer_limit),
        .tc_c     (tc),
        .pre_tc_c (pre_tc)
    );

    // One-unit move of each applied value towards its target.
    always_comb begin
        ws_toward = (cur_wshade < tgt.wshade) ? (cur_wshade + LEVEL_W'(1)) : (cur_wshade - LEVEL_W'(1));
        ln_toward = (cur_lightnum < tgt.lightnum) ? (cur_lightnum + LEVEL_W'(1)) : (cur_lightnum - LEVEL_W'(1));
    end

    // Next state and step enables; exits happen on the edge where the applied value reaches its target.
    always_comb begin
        state_nxt = state;
        ws_step   = 1'b0;
        ln_step   = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = SHADE;
            end
            SHADE: begin
                if (cur_wshade == tgt.wshade) begin
                    state_nxt = LAMP;
                end else if (tc) begin
                    ws_step = 1'b1;
                    if (ws_toward == tgt.wshade) state_nxt = LAMP;
                end
            end
            LAMP: begin
                if (cur_lightnum == tgt.lightnum) begin
                    state_nxt = SETTLE;
                end else if (tc) begin
                    ln_step = 1'b1;
                    if (ln_toward == tgt.lightnum) state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tc) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Timer restarts on every state entry and is held at zero while idle.
    always_comb begin
        timer_clr   = (state_nxt != state) || (state == IDLE);
        timer_limit = (state == SETTLE) ? CNT_W'(SETTLE_CYCLES) : CNT_W'(STEP_CYCLES);
    end

    // State, targets, applied values and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tgt          <= '0;
            cur_lightnum <= '0;
            cur_wshade   <= '0;
            lightstate   <= '0;
            ack          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            shade_up     <= 1'b0;
            shade_dn     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack      <= (state == IDLE) && req;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            shade_up <= (state == SHADE) && !timer_clr && pre_tc && (cur_wshade < tgt.wshade);
            shade_dn <= (state == SHADE) && !timer_clr && pre_tc && (cur_wshade > tgt.wshade);
            if ((state == IDLE) && req) begin
                tgt.lightnum <= tgt_lightnum;
                tgt.wshade   <= tgt_wshade;
            end
            if (ws_step) begin
                cur_wshade <= ws_toward;
            end
            if (ln_step) begin
                cur_lightnum <= ln_toward;
                lightstate   <= therm16(ln_toward);
            end
        end
    end

endmodule

// File: tb/tb_lighting_sequencer.sv
// Directed bench for lighting_sequencer with a completion scoreboard.
module tb_lighting_sequencer;

    localparam int STEP   = 4;
    localparam int SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  tgt_lightnum;
    logic [3:0]  tgt_wshade;
    logic        ack;
    logic        busy;
    logic        done;
    logic [3:0]  cur_lightnum;
    logic [3:0]  cur_wshade;
    logic [15:0] lightstate;
    logic        shade_up;
    logic        shade_dn;

    lighting_sequencer #(
        .STEP_CYCLES   (STEP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .tgt_lightnum (tgt_lightnum),
        .tgt_wshade   (tgt_wshade),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .cur_lightnum (cur_lightnum),
        .cur_wshade   (cur_wshade),
        .lightstate   (lightstate),
        .shade_up     (shade_up),
        .shade_dn     (shade_dn)
    );

    typedef struct {
        int          lat;
        logic [3:0]  ln;
        logic [3:0]  ws;
        logic [15:0] ls;
        int          ups;
        int          dns;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   ups = 0;
    int   dns = 0;
    int   n_acks = 0;
    int   model_ln = 0;
    int   model_ws = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] ln, input logic [3:0] ws);
        req          = r;
        tgt_lightnum = ln;
        tgt_wshade   = ws;
    endtask

    // Reference model: expected completion record for a request from the current model state.
    task automatic push_req(input int ln, input int ws);
        exp_t e;
        int   ds;
        int   dl;
        ds    = (ws > model_ws) ? ws - model_ws : model_ws - ws;
        dl    = (ln > model_ln) ? ln - model_ln : model_ln - ln;
        e.lat = ((ds == 0) ? 1 : ds * STEP) + ((dl == 0) ? 1 : dl * STEP) + SETTLE + 1;
        e.ln  = 4'(ln);
        e.ws  = 4'(ws);
        e.ls  = 16'((32'd1 << ln) - 32'd1);
        e.ups = (ws > model_ws) ? ds : 0;
        e.dns = (ws < model_ws) ? ds : 0;
        sb.push_back(e);
        model_ln = ln;
        model_ws = ws;
    endtask

    task automatic wait_done(input string tag, input int max);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (done !== 1'b1 && i < max);
        check(tag, 32'(done), 32'd1);
    endtask

    // Monitor: pulse accounting per sequence and scoreboard pop on completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                ack_cyc = cyc;
                ups     = 0;
                dns     = 0;
                n_acks++;
            end
            if (shade_up) ups++;
            if (shade_dn) dns++;
            check("motor_exclusive", 32'(shade_up & shade_dn), 32'd0);
            if (done) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_latency", 32'(cyc - ack_cyc + 1), 32'(e.lat));
                    check("sb_lightnum", 32'(cur_lightnum), 32'(e.ln));
                    check("sb_wshade", 32'(cur_wshade), 32'(e.ws));
                    check("sb_lightstate", 32'(lightstate), 32'(e.ls));
                    check("sb_shade_up_cnt", 32'(ups), 32'(e.ups));
                    check("sb_shade_dn_cnt", 32'(dns), 32'(e.dns));
                end
            end
        end
    end

    initial begin
        int acks0;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 4'd0);
        repeat (3) step();
        check("reset_outputs",
              32'({ack, busy, done, cur_lightnum, cur_wshade, lightstate, shade_up, shade_dn}), 32'd0);
        rst_n = 1'b1;
        step();

        // First ramp: 0/0 -> lamps 3, shade 2
        push_req(3, 2);
        drive(1'b1, 4'd3, 4'd2);
        step();
        check("t1_ack", 32'(ack), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 2; c <= 24; c++) begin
            step();
            if (c == 4 || c == 8) check("t1_shade_up", 32'(shade_up), 32'd1);
            if (c == 5) check("t1_shade_up_gap", 32'(shade_up), 32'd0);
            if (c == 12) check("t1_ln_c12", 32'(cur_lightnum), 32'd0);
            if (c == 13) check("t1_ln_c13", 32'(cur_lightnum), 32'd1);
            if (c == 17) check("t1_ln_c17", 32'(cur_lightnum), 32'd2);
            if (c == 21) check("t1_ln_c21", 32'(cur_lightnum), 32'd3);
            if (c == 23) begin
                check("t1_done", 32'(done), 32'd1);
                check("t1_lightstate", 32'(lightstate), 32'h0007);
                check("t1_wshade", 32'(cur_wshade), 32'd2);
            end
            if (c == 24) check("t1_busy_fall", 32'(busy), 32'd0);
        end

        // Lamps down, shade up: 3/2 -> 0/5
        push_req(0, 5);
        drive(1'b1, 4'd0, 4'd5);
        step();
        check("t2_ack", 32'(ack), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 2; c <= 28; c++) begin
            step();
            if (c == 17) check("t2_ls_c17", 32'(lightstate), 32'h0003);
            if (c == 21) check("t2_ls_c21", 32'(lightstate), 32'h0001);
            if (c == 25) check("t2_ls_c25", 32'(lightstate), 32'h0000);
            if (c == 27) check("t2_done", 32'(done), 32'd1);
            if (c == 28) check("t2_idle", 32'(busy), 32'd0);
        end

        // Targets equal to current values
        push_req(0, 5);
        drive(1'b1, 4'd0, 4'd5);
        step();
        check("t3_ack", 32'(ack), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 2; c <= 6; c++) begin
            step();
            if (c == 4) check("t3_no_done_yet", 32'(done), 32'd0);
            if (c == 5) check("t3_done", 32'(done), 32'd1);
            if (c == 6) check("t3_idle", 32'(busy), 32'd0);
        end

        // Requests during busy are ignored
        acks0 = n_acks;
        push_req(7, 9);
        drive(1'b1, 4'd7, 4'd9);
        step();
        check("t4_ack", 32'(ack), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 2; c <= 40; c++) begin
            step();
            if (c % 5 == 1 && c > 2) check("t4_no_ack", 32'(ack), 32'd0);
            if (c % 5 == 0) drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)));
            else drive(1'b0, 4'd0, 4'd0);
        end
        drive(1'b0, 4'd0, 4'd0);
        wait_done("t4_done", 100);
        step();
        check("t4_single_ack", 32'(n_acks - acks0), 32'd1);

        // Asynchronous reset mid-LAMP
        drive(1'b1, 4'd12, 4'd9);
        step();
        check("t5_ack", 32'(ack), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        for (int c = 2; c <= 10; c++) step();
        check("t5_mid_lamp", 32'(cur_lightnum), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_clear",
              32'({ack, busy, done, cur_lightnum, cur_wshade, lightstate, shade_up, shade_dn}), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_ln = 0;
        model_ws = 0;
        step();
        check("t5_idle_after", 32'({busy, cur_lightnum, cur_wshade}), 32'd0);

        // Full range after reset
        push_req(15, 15);
        drive(1'b1, 4'd15, 4'd15);
        step();
        check("t5b_ack", 32'(ack), 32'd1);
        drive(1'b0, 4'd0, 4'd0);
        wait_done("t5b_done", 200);
        check("t5b_lightstate", 32'(lightstate), 32'h7FFF);
        step();

        // req held high: re-accept right after each IDLE entry
        acks0 = n_acks;
        push_req(15, 15);
        drive(1'b1, 4'd15, 4'd15);
        step();
        check("t6_first_ack", 32'(ack), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_done("t6_done", 20);
            step();
            check("t6_idle_busy", 32'(busy), 32'd0);
            check("t6_idle_ack", 32'(ack), 32'd0);
            if (k < 2) push_req(15, 15);
            else drive(1'b0, 4'd0, 4'd0);
            step();
            check("t6_reack", 32'(ack), (k < 2) ? 32'd1 : 32'd0);
        end
        step();
        check("t6_ack_count", 32'(n_acks - acks0), 32'd3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
